// File: rtl/branch_redirect_pkg.sv
// Shared core constants and state encoding for the Execute-stage branch redirect logic.
package branch_redirect_pkg;

  localparam int XLEN         = 32;
  localparam int FLUSH_CYCLES = 2;
  localparam int FCW          = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

endpackage

// File: rtl/branch_redirect_if.sv
// Redirect channel from Execute to the Fetch PC mux, plus the Fetch/Decode kill line.
// Handshake: redirect_valid is raised by the master and held, with redirect_pc stable,
// until the cycle redirect_ready is also high; that cycle is the single transfer.
interface branch_redirect_if #(
  parameter int XLEN = 32
) ();
  logic            redirect_valid;
  logic            redirect_ready;
  logic [XLEN-1:0] redirect_pc;
  logic            flush_fd;

  modport master (output redirect_valid, output redirect_pc, output flush_fd, input redirect_ready);
  modport slave  (input redirect_valid, input redirect_pc, input flush_fd, output redirect_ready);
endinterface

// File: rtl/branch_target_gen.sv
// Combinational target adder/mux (jalr > jal/branch) and pc+4 link value.
module branch_target_gen #(
  parameter int XLEN = 32
) (
  input  logic            is_jalr,
  input  logic [XLEN-1:0] pc_de,
  input  logic [XLEN-1:0] imm_de,
  input  logic [XLEN-1:0] rs1data_de,
  output logic [XLEN-1:0] target,
  output logic [XLEN-1:0] link_data
);
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] pc_rel;

  assign jalr_sum  = rs1data_de + imm_de;
  assign pc_rel    = pc_de + imm_de;
  // JAL and branches share the pc-relative adder; only JALR drops bit 0.
  assign target    = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : pc_rel;
  assign link_data = pc_de + XLEN'(4);
endmodule

// File: rtl/branch_redirect.sv
// Resolves taken jumps/branches, issues the Fetch redirect and times the wrong-path flush.
// Optional BRANCH_MISALIGN_TRAP_EN: targets with bit 1 set trap instead of redirecting.
module branch_redirect #(
  parameter int XLEN         = branch_redirect_pkg::XLEN,
  parameter int FLUSH_CYCLES = branch_redirect_pkg::FLUSH_CYCLES,
  parameter int FCW          = branch_redirect_pkg::FCW
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        exec_valid,
  input  logic                        is_branch,
  input  logic                        is_jal,
  input  logic                        is_jalr,
  input  logic                        jump_state_pre,
  input  logic [XLEN-1:0]             pc_de,
  input  logic [XLEN-1:0]             imm_de,
  input  logic [XLEN-1:0]             rs1data_de,
  branch_redirect_if.master           rd,
  output logic                        stall_ex,
  output logic [XLEN-1:0]             link_data,
`ifdef BRANCH_MISALIGN_TRAP_EN
  output logic                        misalign_trap,
  output logic [XLEN-1:0]             misalign_addr,
`endif
  output branch_redirect_pkg::state_e state_dbg
);
  import branch_redirect_pkg::*;

  state_e          state_q, state_d;
  logic [FCW-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] target;
  logic            taken;

  // A low is_branch masks jump_state_pre, so an unknown comparator result cannot leak out.
  assign taken = exec_valid & (is_jalr | is_jal | (is_branch & jump_state_pre));

  branch_target_gen #(.XLEN(XLEN)) u_target_gen (
    .is_jalr    (is_jalr),
    .pc_de      (pc_de),
    .imm_de     (imm_de),
    .rs1data_de (rs1data_de),
    .target     (target),
    .link_data  (link_data)
  );

`ifdef BRANCH_MISALIGN_TRAP_EN
  logic            trap_q, trap_d;
  logic [XLEN-1:0] maddr_q, maddr_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
`ifdef BRANCH_MISALIGN_TRAP_EN
      trap_q  <= 1'b0;
      maddr_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
`ifdef BRANCH_MISALIGN_TRAP_EN
      trap_q  <= trap_d;
      maddr_q <= maddr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
`ifdef BRANCH_MISALIGN_TRAP_EN
    trap_d  = 1'b0;
    maddr_d = maddr_q;
`endif
    case (state_q)
      IDLE: begin
        if (taken) begin
`ifdef BRANCH_MISALIGN_TRAP_EN
          if (target[1]) begin
            trap_d  = 1'b1;
            maddr_d = target;
          end else begin
            pc_d    = target;
            state_d = REDIRECT;
          end
`else
          pc_d    = target;
          state_d = REDIRECT;
`endif
        end
      end
      REDIRECT: begin
        if (rd.redirect_ready) begin
          if (FLUSH_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            cnt_d   = FCW'(FLUSH_CYCLES - 1);
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd.redirect_valid = (state_q == REDIRECT);
    rd.flush_fd       = (state_q != IDLE);
    stall_ex          = (state_q != IDLE);
    rd.redirect_pc    = pc_q;
    state_dbg         = state_q;
  end

`ifdef BRANCH_MISALIGN_TRAP_EN
  assign misalign_trap = trap_q;
  assign misalign_addr = maddr_q;
`endif
endmodule

// File: tb/tb_branch_redirect.sv
// Directed bench for branch_redirect: per-cycle model comparison plus literal spot checks.
module tb_branch_redirect;
  import branch_redirect_pkg::*;

  localparam int W  = 32;
  localparam int FC = 2;

  logic         clk, rst_n;
  logic         exec_valid, is_branch, is_jal, is_jalr, jump_state_pre;
  logic [W-1:0] pc_de, imm_de, rs1data_de;
  logic         stall_ex;
  logic [W-1:0] link_data;
  state_e       state_dbg;
`ifdef BRANCH_MISALIGN_TRAP_EN
  logic         misalign_trap;
  logic [W-1:0] misalign_addr;
`endif

  branch_redirect_if #(.XLEN(W)) rif ();

  branch_redirect #(.XLEN(W), .FLUSH_CYCLES(FC), .FCW(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .exec_valid     (exec_valid),
    .is_branch      (is_branch),
    .is_jal         (is_jal),
    .is_jalr        (is_jalr),
    .jump_state_pre (jump_state_pre),
    .pc_de          (pc_de),
    .imm_de         (imm_de),
    .rs1data_de     (rs1data_de),
    .rd             (rif),
    .stall_ex       (stall_ex),
    .link_data      (link_data),
`ifdef BRANCH_MISALIGN_TRAP_EN
    .misalign_trap  (misalign_trap),
    .misalign_addr  (misalign_addr),
`endif
    .state_dbg      (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Model terms: a redirect is "pending" until Fetch takes it, then "flush_left"
  // cycles of wrong-path kill remain.
  logic         m_pending;
  int           m_flush_left;
  logic [W-1:0] m_pc;
  logic         m_trap;
  logic [W-1:0] m_maddr;
  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] model_target(input logic jalr, input logic [W-1:0] pc,
                                                 input logic [W-1:0] imm, input logic [W-1:0] rs1);
    logic [W-1:0] s;
    if (jalr) begin
      s = rs1 + imm;
      return s & ~32'd1;
    end
    return pc + imm;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pending    = 1'b0;
      m_flush_left = 0;
      m_pc         = '0;
      m_trap       = 1'b0;
      m_maddr      = '0;
      exp_q.delete();
    end else begin
      logic         tk;
      logic [W-1:0] tgt;
      tk  = exec_valid && (is_jalr || is_jal || (is_branch && jump_state_pre === 1'b1));
      tgt = model_target(is_jalr, pc_de, imm_de, rs1data_de);
      m_trap = 1'b0;
      if (m_pending) begin
        if (rif.redirect_ready) begin
          m_pending    = 1'b0;
          m_flush_left = FC;
        end
      end else if (m_flush_left > 0) begin
        m_flush_left = m_flush_left - 1;
      end else if (tk) begin
`ifdef BRANCH_MISALIGN_TRAP_EN
        if (tgt[1]) begin
          m_trap  = 1'b1;
          m_maddr = tgt;
        end else begin
          m_pending = 1'b1;
          m_pc      = tgt;
          exp_q.push_back(tgt);
        end
`else
        m_pending = 1'b1;
        m_pc      = tgt;
        exp_q.push_back(tgt);
`endif
      end
    end
  end

  function automatic logic model_busy();
    return m_pending || (m_flush_left > 0);
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [W-1:0] front;
    chk("redirect_valid", W'(rif.redirect_valid), W'(m_pending));
    chk("flush_fd", W'(rif.flush_fd), W'(model_busy()));
    chk("stall_ex", W'(stall_ex), W'(model_busy()));
    chk("link_data", link_data, pc_de + 32'd4);
    if (m_pending) chk("redirect_pc", rif.redirect_pc, m_pc);
    if (rif.redirect_valid && rif.redirect_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_handshake", 32'd1, 32'd0);
      end else begin
        front = exp_q.pop_front();
        chk("handshake_pc", rif.redirect_pc, front);
      end
    end
`ifdef BRANCH_MISALIGN_TRAP_EN
    chk("misalign_trap", W'(misalign_trap), W'(m_trap));
    if (m_trap) chk("misalign_addr", misalign_addr, m_maddr);
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    exec_valid     = 1'b0;
    is_branch      = 1'b0;
    is_jal         = 1'b0;
    is_jalr        = 1'b0;
    jump_state_pre = 1'b0;
  endtask

  // Presents one instruction in Execute for one cycle, then leaves the bus idle.
  task automatic issue(input logic br, input logic jal, input logic jalr, input logic jsp,
                       input logic [W-1:0] pc, input logic [W-1:0] imm, input logic [W-1:0] rs1);
    exec_valid     = 1'b1;
    is_branch      = br;
    is_jal         = jal;
    is_jalr        = jalr;
    jump_state_pre = jsp;
    pc_de          = pc;
    imm_de         = imm;
    rs1data_de     = rs1;
    step();
    clear_inputs();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (model_busy() && n < 20) begin
      step();
      n++;
    end
    if (model_busy()) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  // ---------------- directed vectors ----------------
  initial begin
    int n;
    clear_inputs();
    pc_de = '0; imm_de = '0; rs1data_de = '0;
    rif.redirect_ready = 1'b1;
    rst_n = 1'b0;
    #12;
    chk("reset_valid", W'(rif.redirect_valid), 32'd0);
    chk("reset_pc", rif.redirect_pc, 32'd0);
    chk("reset_flush", W'(rif.flush_fd), 32'd0);
    chk("reset_stall", W'(stall_ex), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();

    // JAL 0x100+0x20, ready high: 1 redirect cycle + 2 flush cycles.
    pc_de = 32'h100;
    #1 chk("jal_link", link_data, 32'h104);
    issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h20, 32'h0);
    chk("jal_valid", W'(rif.redirect_valid), 32'd1);
    chk("jal_pc", rif.redirect_pc, 32'h120);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (!rif.flush_fd) break;
      n++;
      step();
    end
    chk("jal_flush_len", 32'(n), 32'd3);
    chk("jal_stall_after", W'(stall_ex), 32'd0);

    // JALR with bit-0 clear; hold ready low one cycle first.
    rif.redirect_ready = 1'b0;
    issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h4, 32'h1001);
    chk("jalr_pc", rif.redirect_pc, 32'h1004);
    step();
    rif.redirect_ready = 1'b1;
    wait_idle();

    // Taken backward branch.
    issue(1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 32'hFFFF_FFF0, 32'h0);
    chk("branch_pc", rif.redirect_pc, 32'h1F0);
    wait_idle();

    // Not-taken branch: nothing happens.
    issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 32'h40, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("nt_valid", W'(rif.redirect_valid), 32'd0);
      chk("nt_flush", W'(rif.flush_fd), 32'd0);
      step();
    end

    // Unknown comparator result with no branch qualifier.
    issue(1'b0, 1'b0, 1'b0, 1'bx, 32'h240, 32'h40, 32'h0);
    chk("x_valid", W'(rif.redirect_valid), 32'd0);
    chk("x_stall", W'(stall_ex), 32'd0);

    // All qualifiers high: jalr wins.
    issue(1'b1, 1'b1, 1'b1, 1'b1, 32'h400, 32'h8, 32'h801);
    chk("prio_pc", rif.redirect_pc, 32'h808);
    wait_idle();

    // Wrap-around target and link.
    pc_de = 32'hFFFF_FFFC;
    #1 chk("wrap_link", link_data, 32'h0);
    issue(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h20, 32'h0);
    chk("wrap_pc", rif.redirect_pc, 32'h10);
    wait_idle();

    // Backpressure: 4 cycles held, then handshake and 2 flush cycles.
    rif.redirect_ready = 1'b0;
    issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h20, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", W'(rif.redirect_valid), 32'd1);
      chk("bp_pc", rif.redirect_pc, 32'h120);
      chk("bp_stall", W'(stall_ex), 32'd1);
      if (i < 3) step();
    end
    rif.redirect_ready = 1'b1;
    step();
    chk("bp_flush1_valid", W'(rif.redirect_valid), 32'd0);
    chk("bp_flush1", W'(rif.flush_fd), 32'd1);
    step();
    chk("bp_flush2", W'(rif.flush_fd), 32'd1);
    step();
    chk("bp_done", W'(rif.flush_fd), 32'd0);

    // Reset mid-flush, then a normal redirect.
    issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h20, 32'h0);
    step();
    chk("rst_in_flush", W'(rif.flush_fd), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_flush", W'(rif.flush_fd), 32'd0);
    chk("rst_async_stall", W'(stall_ex), 32'd0);
    chk("rst_async_valid", W'(rif.redirect_valid), 32'd0);
    chk("rst_async_pc", rif.redirect_pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h300, 32'h10, 32'h0);
    chk("post_rst_pc", rif.redirect_pc, 32'h310);
    wait_idle();

    // Misaligned (bit 1) target.
    issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h22, 32'h0);
`ifdef BRANCH_MISALIGN_TRAP_EN
    chk("mis_trap", W'(misalign_trap), 32'd1);
    chk("mis_addr", misalign_addr, 32'h122);
    chk("mis_no_valid", W'(rif.redirect_valid), 32'd0);
    step();
    chk("mis_pulse_end", W'(misalign_trap), 32'd0);
`else
    chk("mis_redirect_pc", rif.redirect_pc, 32'h122);
    chk("mis_redirect_valid", W'(rif.redirect_valid), 32'd1);
`endif
    wait_idle();
    step();

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
